rhs_spi_master: RTL



---
 rtl/rhs_spi_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rhs_spi_master.sv
// SPI master for one acquisition sweep over an RHS-family front end.
// Sends one CONVERT command per frame and realigns the two-frame-late
// MISO results to the channel that produced them.
module rhs_spi_master #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned NUM_CHANNELS   = 16,
  parameter int unsigned CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        CS,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [4:0]  cmd_channel,
  output logic [15:0] sample_data,
  output logic [4:0]  sample_channel,
  output logic        sample_valid,
  output logic        sweep_done
);

  localparam int unsigned DivMax = (CLK_DIV > CS_HIGH_CYCLES) ? CLK_DIV : CS_HIGH_CYCLES;
  localparam int unsigned CntW   = (DivMax > 1) ? $clog2(DivMax) : 1;
  localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(CS_HIGH_CYCLES - 1);
  localparam logic [5:0]      NumCh     = 6'(NUM_CHANNELS);
  localparam logic [5:0]      LastFrame = 6'(NUM_CHANNELS + 1);

  typedef enum logic [2:0] {StIdle, StCsSetup, StHigh, StLow, StCsGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] div_q, div_d;
  logic [4:0]      bit_q, bit_d;
  logic [5:0]      frame_q, frame_d;
  logic [31:0]     tx_q, tx_d;
  logic [31:0]     rx_q, rx_d;
  logic [4:0]      cmd_ch_q, cmd_ch_d;
  logic            sv_q, sv_d;
  logic [15:0]     sd_q, sd_d;
  logic [4:0]      sch_q, sch_d;

  logic [5:0] next_frame;
  logic [4:0] next_ch;
  logic       div_last, gap_last, cs_active;

  assign div_last = (div_q == DivLast);
  assign gap_last = (div_q == GapLast);

  // Channel for the following frame; the two trailing dummy frames wrap to 0 and 1.
  always_comb begin
    next_frame = frame_q + 6'd1;
    next_ch    = (next_frame < NumCh) ? next_frame[4:0] : 5'(next_frame - NumCh);
  end

  // Frame sequencer: next state, counters, shift registers and sample strobe.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    cmd_ch_d = cmd_ch_q;
    sv_d     = 1'b0;
    sd_d     = sd_q;
    sch_d    = sch_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCsSetup;
          div_d    = '0;
          bit_d    = 5'd31;
          frame_d  = '0;
          cmd_ch_d = '0;
          tx_d     = '0;
        end
      end
      StCsSetup: begin
        if (div_last) begin
          state_d = StHigh;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StHigh: begin
        if (div_last) begin
          // Sample just before SCLK falls; the slave updates MISO on that edge.
          rx_d    = {rx_q[30:0], MISO};
          tx_d    = {tx_q[30:0], 1'b0};
          state_d = StLow;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StLow: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == 5'd0) begin
            state_d = StCsGap;
            // Frames 0 and 1 carry results of commands from before this sweep.
            if (frame_q >= 6'd2) begin
              sv_d  = 1'b1;
              sd_d  = rx_q[31:16];
              sch_d = 5'(frame_q - 6'd2);
            end
          end else begin
            bit_d   = bit_q - 5'd1;
            state_d = StHigh;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StCsGap: begin
        if (gap_last) begin
          div_d = '0;
          if (frame_q == LastFrame) begin
            state_d = StIdle;
            frame_d = '0;
          end else begin
            state_d  = StCsSetup;
            frame_d  = next_frame;
            bit_d    = 5'd31;
            cmd_ch_d = next_ch;
            tx_d     = {11'b0, next_ch, 16'h0000};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      cmd_ch_q <= '0;
      sv_q     <= 1'b0;
      sd_q     <= '0;
      sch_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      cmd_ch_q <= cmd_ch_d;
      sv_q     <= sv_d;
      sd_q     <= sd_d;
      sch_q    <= sch_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    cs_active      = (state_q == StCsSetup) || (state_q == StHigh) || (state_q == StLow);
    busy           = (state_q != StIdle);
    CS             = ~cs_active;
    SCLK           = (state_q == StHigh);
    MOSI           = cs_active & tx_q[31];
    cmd_channel    = cmd_ch_q;
    sample_data    = sd_q;
    sample_channel = sch_q;
    sample_valid   = sv_q;
    sweep_done     = (state_q == StCsGap) && gap_last && (frame_q == LastFrame);
  end

endmodule
